// File: rtl/complex_mult_pkg.sv
// rtl/complex_mult_pkg.sv - shared widths and tag type for the complex multiplier scheduler
package complex_mult_pkg;

  localparam int A_W              = 18;
  localparam int B_W              = 17;
  localparam int P_W              = 35;
  localparam int MULT_LAT_DEFAULT = 7;

  // Wide enough for the largest supported requester count (8)
  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at an external pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_REQ-1:0] upper;
  logic [NUM_REQ-1:0] cand;

  // Requests at or above the pointer win first; otherwise wrap to the lowest request
  always_comb begin
    upper = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      upper[j] = req[j] && (j >= int'(ptr));
    end
    cand = (|upper) ? upper : req;
  end

  // Lowest set candidate becomes the one-hot grant and its encoded index
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (cand[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/complex_mult_scheduler.sv
// rtl/complex_mult_scheduler.sv - shares one pipelined complex multiplier among round-robin requesters
module complex_mult_scheduler
  import complex_mult_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int MULT_LAT = MULT_LAT_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [NUM_REQ*A_W-1:0] i_ar,
  input  logic [NUM_REQ*A_W-1:0] i_ai,
  input  logic [NUM_REQ*B_W-1:0] i_br,
  input  logic [NUM_REQ*B_W-1:0] i_bi,
  output logic [NUM_REQ-1:0]     o_gnt,
  output logic [A_W-1:0]         o_mul_ar,
  output logic [A_W-1:0]         o_mul_ai,
  output logic [B_W-1:0]         o_mul_br,
  output logic [B_W-1:0]         o_mul_bi,
  input  logic [P_W-1:0]         i_mul_pr,
  input  logic [P_W-1:0]         i_mul_pi,
  output logic                   o_vld,
  output logic [ID_W-1:0]        o_id,
  output logic [P_W-1:0]         o_pr,
  output logic [P_W-1:0]         o_pi,
  output logic                   o_busy
);

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    arb_idx;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               granted;
  logic [A_W-1:0]     sel_ar;
  logic [A_W-1:0]     sel_ai;
  logic [B_W-1:0]     sel_br;
  logic [B_W-1:0]     sel_bi;
  tag_t               tags [MULT_LAT+1];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_arb (
    .req (i_req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Nothing is granted while reset is held, even with requests pending
  assign o_gnt   = i_rst ? '0 : arb_gnt;
  assign granted = |o_gnt;

  // Round-robin pointer moves just past the winner; idle cycles leave it alone
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr <= '0;
    end else if (granted) begin
      ptr <= (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
    end
  end

  // Pick the granted requester's operands out of the packed buses
  always_comb begin
    sel_ar = '0;
    sel_ai = '0;
    sel_br = '0;
    sel_bi = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (arb_idx == ID_W'(j)) begin
        sel_ar = i_ar[j*A_W +: A_W];
        sel_ai = i_ai[j*A_W +: A_W];
        sel_br = i_br[j*B_W +: B_W];
        sel_bi = i_bi[j*B_W +: B_W];
      end
    end
  end

  // Issue register: zeros go down the multiplier on idle cycles
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mul_ar <= '0;
      o_mul_ai <= '0;
      o_mul_br <= '0;
      o_mul_bi <= '0;
    end else if (granted) begin
      o_mul_ar <= sel_ar;
      o_mul_ai <= sel_ai;
      o_mul_br <= sel_br;
      o_mul_bi <= sel_bi;
    end else begin
      o_mul_ar <= '0;
      o_mul_ai <= '0;
      o_mul_br <= '0;
      o_mul_bi <= '0;
    end
  end

  // Tag line shadows the multiplier; the last stage lines up with i_mul_pr/pi
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s <= MULT_LAT; s++) begin
        tags[s] <= '0;
      end
    end else begin
      tags[0].valid <= granted;
      tags[0].id    <= TAG_ID_W'(arb_idx);
      for (int s = 1; s <= MULT_LAT; s++) begin
        tags[s] <= tags[s-1];
      end
    end
  end

  // Output register holds the last result across idle cycles
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_vld <= 1'b0;
      o_id  <= '0;
      o_pr  <= '0;
      o_pi  <= '0;
    end else begin
      o_vld <= tags[MULT_LAT].valid;
      if (tags[MULT_LAT].valid) begin
        o_id <= tags[MULT_LAT].id[ID_W-1:0];
        o_pr <= i_mul_pr;
        o_pi <= i_mul_pi;
      end
    end
  end

  // Busy while any operation sits in the tag line or the output register
  always_comb begin
    o_busy = o_vld;
    for (int s = 0; s <= MULT_LAT; s++) begin
      o_busy = o_busy | tags[s].valid;
    end
  end

endmodule

// File: tb/tb_complex_mult_scheduler.sv
// tb/tb_complex_mult_scheduler.sv - randomized and directed checks of the multiplier scheduler
module tb_complex_mult_scheduler;

  localparam int N   = 4;
  localparam int LAT = 9;
  localparam int ML  = 7;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [N-1:0]  i_req;
  logic [N*18-1:0] i_ar, i_ai;
  logic [N*17-1:0] i_br, i_bi;
  logic [N-1:0]  o_gnt;
  logic [17:0]   o_mul_ar, o_mul_ai;
  logic [16:0]   o_mul_br, o_mul_bi;
  logic [34:0]   i_mul_pr, i_mul_pi;
  logic          o_vld;
  logic [1:0]    o_id;
  logic [34:0]   o_pr, o_pi;
  logic          o_busy;

  complex_mult_scheduler #(.NUM_REQ(N), .ID_W(2), .MULT_LAT(ML)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req),
    .i_ar(i_ar), .i_ai(i_ai), .i_br(i_br), .i_bi(i_bi),
    .o_gnt(o_gnt),
    .o_mul_ar(o_mul_ar), .o_mul_ai(o_mul_ai), .o_mul_br(o_mul_br), .o_mul_bi(o_mul_bi),
    .i_mul_pr(i_mul_pr), .i_mul_pi(i_mul_pi),
    .o_vld(o_vld), .o_id(o_id), .o_pr(o_pr), .o_pi(o_pi), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic longint wrap35(input longint v);
    logic signed [34:0] t;
    t = v[34:0];
    return longint'(t);
  endfunction

  // External 7-cycle multiplier model fed from the issue register
  logic [34:0] mp_r [ML];
  logic [34:0] mp_i [ML];
  always @(posedge i_clk) begin
    mp_r[0] <= 35'(wrap35(longint'($signed(o_mul_ar)) * longint'($signed(o_mul_br))
                        - longint'($signed(o_mul_ai)) * longint'($signed(o_mul_bi))));
    mp_i[0] <= 35'(wrap35(longint'($signed(o_mul_ar)) * longint'($signed(o_mul_bi))
                        + longint'($signed(o_mul_ai)) * longint'($signed(o_mul_br))));
    for (int s = 1; s < ML; s++) begin
      mp_r[s] <= mp_r[s-1];
      mp_i[s] <= mp_i[s-1];
    end
  end
  assign i_mul_pr = mp_r[ML-1];
  assign i_mul_pi = mp_i[ML-1];

  // Requester-side state and reference model
  logic [N-1:0]       req_v;
  logic signed [17:0] ar_v [N];
  logic signed [17:0] ai_v [N];
  logic signed [16:0] br_v [N];
  logic signed [16:0] bi_v [N];
  int                 remaining [N];
  int                 mptr = 0;

  typedef struct { int id; longint pr; longint pi; int due; } exp_t;
  exp_t   q [$];
  int     id_log [$];
  int     vld_count = 0;
  longint last_pr = 0;
  longint last_pi = 0;

  // Result monitor: each valid must match the oldest outstanding grant
  always @(negedge i_clk) begin
    if (!i_rst && o_vld === 1'b1) begin
      vld_count++;
      if (q.size() == 0) begin
        check("vld_unexpected", o_vld, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("res_id", o_id, e.id);
        check("res_pr", $signed(o_pr), e.pr);
        check("res_pi", $signed(o_pi), e.pi);
        check("res_latency", cyc, e.due);
        id_log.push_back(e.id);
        last_pr = e.pr;
        last_pi = e.pi;
      end
    end
  end

  task automatic drive();
    i_req = req_v;
    for (int k = 0; k < N; k++) begin
      i_ar[k*18 +: 18] = ar_v[k];
      i_ai[k*18 +: 18] = ai_v[k];
      i_br[k*17 +: 17] = br_v[k];
      i_bi[k*17 +: 17] = bi_v[k];
    end
  endtask

  task automatic rand_ops(input int k);
    ar_v[k] = 18'($urandom);
    ai_v[k] = 18'($urandom);
    br_v[k] = 17'($urandom);
    bi_v[k] = 17'($urandom);
  endtask

  task automatic set_op(input int k, input int ar, input int ai, input int br, input int bi, input int n);
    ar_v[k] = 18'(ar);
    ai_v[k] = 18'(ai);
    br_v[k] = 17'(br);
    bi_v[k] = 17'(bi);
    req_v[k] = 1'b1;
    remaining[k] = n;
  endtask

  task automatic set_rand(input int k, input int n);
    rand_ops(k);
    req_v[k] = 1'b1;
    remaining[k] = n;
  endtask

  function automatic int model_pick();
    for (int i = 0; i < N; i++) begin
      if (req_v[(mptr + i) % N]) return (mptr + i) % N;
    end
    return -1;
  endfunction

  // One clock: present inputs, predict and check the grant, then advance requesters
  task automatic cycle();
    int g;
    exp_t e;
    drive();
    @(negedge i_clk);
    g = model_pick();
    check("gnt", o_gnt, (g < 0) ? 64'sd0 : (64'sd1 <<< g));
    if (g >= 0) begin
      e.id  = g;
      e.pr  = wrap35(longint'(ar_v[g]) * longint'(br_v[g]) - longint'(ai_v[g]) * longint'(bi_v[g]));
      e.pi  = wrap35(longint'(ar_v[g]) * longint'(bi_v[g]) + longint'(ai_v[g]) * longint'(br_v[g]));
      e.due = cyc + LAT;
      q.push_back(e);
      mptr = (g + 1) % N;
      remaining[g]--;
    end
    @(posedge i_clk);
    #1;
    if (g >= 0) begin
      if (remaining[g] > 0) rand_ops(g);
      else req_v[g] = 1'b0;
    end
  endtask

  task automatic drain();
    int budget = 40;
    while (q.size() > 0 && budget > 0) begin
      cycle();
      budget--;
    end
    check("drain_timeout", q.size(), 0);
    cycle();
  endtask

  initial begin
    int v0;
    req_v = '0;
    for (int k = 0; k < N; k++) begin
      ar_v[k] = '0; ai_v[k] = '0; br_v[k] = '0; bi_v[k] = '0; remaining[k] = 0;
    end
    drive();

    // Reset state, with a request already pending
    repeat (2) @(posedge i_clk);
    #1;
    set_op(0, 3, 2, 5, -4, 1);
    drive();
    #1;
    check("rst_gnt", o_gnt, 0);
    check("rst_vld", o_vld, 0);
    check("rst_busy", o_busy, 0);
    check("rst_pr", o_pr, 0);
    check("rst_mul_ar", o_mul_ar, 0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // Single isolated op
    cycle();
    check("single_busy", o_busy, 1);
    drain();
    check("single_count", vld_count, 1);
    check("single_pr", $signed(o_pr), 23);
    check("single_pi", $signed(o_pi), -2);
    check("single_id", o_id, 0);

    // Saturated load: 12 back-to-back grants
    v0 = vld_count;
    for (int k = 0; k < N; k++) set_rand(k, 3);
    repeat (12) cycle();
    drain();
    check("sat_count", vld_count - v0, 12);

    // Wrap fairness: req2, then req1 and req3 together
    id_log.delete();
    set_rand(2, 1);
    cycle();
    set_rand(1, 1);
    set_rand(3, 1);
    cycle();
    cycle();
    drain();
    check("wrap_n", id_log.size(), 3);
    if (id_log.size() == 3) begin
      check("wrap_id0", id_log[0], 2);
      check("wrap_id1", id_log[1], 3);
      check("wrap_id2", id_log[2], 1);
    end

    // Extreme operands
    set_op(0, -131072, 0, -65536, 0, 1);
    cycle();
    drain();
    check("ext_pr_pos", $signed(o_pr), 64'sd8589934592);
    check("ext_pi_pos", $signed(o_pi), 0);
    set_op(1, 0, -131072, 0, -65536, 1);
    cycle();
    drain();
    check("ext_pr_neg", $signed(o_pr), -64'sd8589934592);

    // Random traffic
    for (int c = 0; c < 40; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!req_v[k] && $urandom_range(0, 3) == 0) set_rand(k, $urandom_range(1, 3));
      end
      cycle();
    end
    for (int k = 0; k < N; k++) remaining[k] = (remaining[k] > 0) ? 1 : 0;
    repeat (8) cycle();
    drain();

    // Idle hold
    v0 = vld_count;
    repeat (20) cycle();
    check("idle_vld", vld_count - v0, 0);
    check("idle_pr_hold", $signed(o_pr), last_pr);
    check("idle_pi_hold", $signed(o_pi), last_pi);
    check("idle_mul_ar", o_mul_ar, 0);
    check("idle_busy", o_busy, 0);

    // Reset with three ops in flight
    set_rand(0, 1);
    set_rand(1, 1);
    set_rand(2, 1);
    repeat (3) cycle();
    check("flight_busy", o_busy, 1);
    req_v[3] = 1'b1;
    remaining[3] = 1;
    drive();
    i_rst = 1'b1;
    #1;
    check("midrst_busy", o_busy, 0);
    check("midrst_gnt", o_gnt, 0);
    check("midrst_vld", o_vld, 0);
    q.delete();
    mptr = 0;
    req_v = '0;
    drive();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    v0 = vld_count;
    repeat (12) cycle();
    check("post_rst_vld", vld_count - v0, 0);

    // Requests held through reset are arbitrated from index 0
    set_rand(1, 1);
    set_rand(3, 1);
    drive();
    i_rst = 1'b1;
    mptr = 0;
    @(posedge i_clk);
    #1;
    check("rst_req_gnt", o_gnt, 0);
    i_rst = 1'b0;
    cycle();
    cycle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
